// File: rtl/ram_cmd_frontend.sv
// ram_cmd_frontend: synchronise and debounce board inputs into one-shot RAM command strobes
module ram_cmd_frontend #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switch,
  input  logic       push_btn,
  output logic [1:0] cmd_mode,
  output logic [1:0] cmd_addr,
  output logic [3:0] cmd_wdata,
  output logic       wr_en,
  output logic       rd_en,
  output logic       bad_cmd,
  output logic       busy,
  output logic [7:0] cmd_count
);
  typedef enum logic [1:0] {IDLE, LATCH, ISSUE, WAIT_REL} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_sw1, r_sw2;
  logic            r_btn1, r_btn2;
  logic            r_btn_stable;
  logic [DB_W-1:0] r_db_cnt;
  // two-flop synchronisers; only the second stage feeds the rest of the block
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sw1  <= '0;
      r_sw2  <= '0;
      r_btn1 <= 1'b0;
      r_btn2 <= 1'b0;
    end else begin
      r_sw1  <= switch;
      r_sw2  <= r_sw1;
      r_btn1 <= push_btn;
      r_btn2 <= r_btn1;
    end
  // stable state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_btn_stable <= 1'b0;
      r_db_cnt     <= '0;
    end else if (r_btn2 == r_btn_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_btn_stable <= r_btn2;
      r_db_cnt     <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: one pass through LATCH/ISSUE per debounced press
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = r_btn_stable ? LATCH : IDLE;
      LATCH:    w_next = ISSUE;
      ISSUE:    w_next = WAIT_REL;
      WAIT_REL: w_next = r_btn_stable ? WAIT_REL : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // capture fields on press, raise the strobe for the ISSUE cycle, count real accesses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_mode  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      bad_cmd   <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (r_state == IDLE && r_btn_stable) begin
        cmd_mode  <= r_sw2[7:6];
        cmd_wdata <= r_sw2[5:2];
        cmd_addr  <= r_sw2[1:0];
      end
      wr_en   <= (r_state == LATCH) && (cmd_mode == 2'b10);
      rd_en   <= (r_state == LATCH) && (cmd_mode == 2'b01);
      bad_cmd <= (r_state == LATCH) && (cmd_mode == 2'b11);
      if (r_state == ISSUE && (wr_en || rd_en)) cmd_count <= cmd_count + 8'd1;
    end
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_ram_cmd_frontend.sv
// tb_ram_cmd_frontend: scoreboard bench for the debounced command front-end
module tb_ram_cmd_frontend;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] switch;
  logic       push_btn;
  logic [1:0] cmd_mode, cmd_addr;
  logic [3:0] cmd_wdata;
  logic       wr_en, rd_en, bad_cmd, busy;
  logic [7:0] cmd_count;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [7:0] cnt;
  } item_t;

  item_t      q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cnt_model = 8'd0;
  logic       prev_strobe = 1'b0;

  ram_cmd_frontend #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .push_btn(push_btn),
    .cmd_mode(cmd_mode), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .wr_en(wr_en), .rd_en(rd_en), .bad_cmd(bad_cmd), .busy(busy),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_cmd(input logic [1:0] k, input logic [7:0] sw);
    item_t it;
    it.kind  = k;
    it.addr  = sw[1:0];
    it.wdata = sw[5:2];
    it.cnt   = cnt_model;
    q.push_back(it);
    if (k == 2'b10 || k == 2'b01) cnt_model = cnt_model + 8'd1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic press(input logic [7:0] sw, input logic [1:0] k);
    switch = sw;
    repeat (3) tick();
    if (k != 2'b00) expect_cmd(k, sw);
    push_btn = 1'b1;
    repeat (12) tick();
    push_btn = 1'b0;
    wait_idle();
    chk("count_after_press", cmd_count, cnt_model);
  endtask

  task automatic hold(input logic v, input int n);
    push_btn = v;
    repeat (n) tick();
  endtask

  // monitor: every strobe must match the oldest expected command
  always @(negedge clk) begin
    item_t it;
    if (wr_en | rd_en | bad_cmd) begin
      chk("strobe_single_cycle", prev_strobe, 0);
      if (q.size() == 0) chk("unexpected_strobe", {wr_en, rd_en, bad_cmd}, 0);
      else begin
        it = q.pop_front();
        chk("strobe_kind", {wr_en, rd_en, bad_cmd},
            {it.kind == 2'b10, it.kind == 2'b01, it.kind == 2'b11});
        chk("strobe_mode", cmd_mode, it.kind);
        chk("strobe_addr", cmd_addr, it.addr);
        chk("strobe_wdata", cmd_wdata, it.wdata);
        chk("strobe_count", cmd_count, it.cnt);
      end
    end
    prev_strobe = wr_en | rd_en | bad_cmd;
  end

  initial begin
    rst_n = 1'b0;
    switch = 8'h00;
    push_btn = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {wr_en, rd_en, bad_cmd}, 0);
    chk("rst_fields", {cmd_mode, cmd_addr, cmd_wdata}, 0);
    chk("rst_count", cmd_count, 0);
    rst_n = 1'b1;
    tick();

    // exact timing of a clean write press, plus switch change after capture
    switch = 8'b10_1011_10;
    repeat (3) tick();
    expect_cmd(2'b10, 8'b10_1011_10);
    push_btn = 1'b1;
    repeat (6) tick();
    chk("t_edge6_busy", busy, 0);
    tick();
    chk("t_edge7_busy", busy, 1);
    chk("t_edge7_mode", cmd_mode, 2'b10);
    chk("t_edge7_addr", cmd_addr, 2'd2);
    chk("t_edge7_wdata", cmd_wdata, 4'hB);
    chk("t_edge7_strobe", {wr_en, rd_en, bad_cmd}, 0);
    switch = 8'b10_0101_10;
    tick();
    chk("t_edge8_wr", wr_en, 1);
    chk("t_edge8_rd", rd_en, 0);
    tick();
    chk("t_edge9_wr", wr_en, 0);
    chk("t_edge9_count", cmd_count, 1);
    chk("t_hold_wdata", cmd_wdata, 4'hB);
    repeat (3) tick();
    push_btn = 1'b0;
    wait_idle();
    chk("t_hold_wdata2", cmd_wdata, 4'hB);
    press(8'b10_0101_10, 2'b10);
    chk("next_wdata", cmd_wdata, 4'h5);

    // read, nop and bad modes
    press(8'b01_0110_11, 2'b01);
    chk("rd_addr", cmd_addr, 2'd3);
    press(8'b00_1111_01, 2'b00);
    press(8'b11_0010_00, 2'b11);

    // bouncy press and bouncy release give one write
    switch = 8'b10_0001_01;
    repeat (3) tick();
    expect_cmd(2'b10, 8'b10_0001_01);
    hold(1, 2); hold(0, 1); hold(1, 3); hold(0, 2); hold(1, 12);
    hold(0, 2); hold(1, 1); hold(0, 3); hold(1, 2);
    chk("bounce_busy_held", busy, 1);
    push_btn = 1'b0;
    tick();
    chk("bounce_busy_after_low", busy, 1);
    wait_idle();
    chk("bounce_count", cmd_count, cnt_model);

    // short glitch is discarded
    hold(1, 3);
    push_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_busy", busy, 0);
    end

    // async reset during ISSUE, button held through release
    switch = 8'b10_1100_01;
    repeat (3) tick();
    push_btn = 1'b1;
    repeat (8) tick();
    chk("pre_rst_wr", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", wr_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", cmd_count, 0);
    chk("async_rst_fields", {cmd_mode, cmd_addr, cmd_wdata}, 0);
    cnt_model = 8'd0;
    repeat (3) tick();
    expect_cmd(2'b10, 8'b10_1100_01);
    rst_n = 1'b1;
    repeat (14) tick();
    push_btn = 1'b0;
    wait_idle();
    chk("held_rst_count", cmd_count, 1);

    // 256 writes wrap the counter back to zero
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt_model = 8'd0;
    tick();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      press({2'b10, v[3:0], v[5:4]}, 2'b10);
    end
    chk("wrap_count", cmd_count, 0);

    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_cmd_frontend.md
# ram_cmd_frontend

Front-end stage that turns raw board inputs (8 slide switches plus one push button) into clean, single-cycle command strobes for the 4x4 switch-driven RAM stage directly downstream. It synchronises all inputs, debounces the push button, latches the switch command at the moment of a press, and issues exactly one write or read strobe per press. This replaces level-sensitive switch decoding with an edge-triggered, glitch-free command interface.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronised button must differ from its stable state before the stable state flips; minimum 2.
- DB_W, 18, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- switch  in  8  raw switches: [7:6] mode, [5:2] data, [1:0] address.
- push_btn  in  1  raw active-high button, asynchronous and bouncy.
- cmd_mode  out  2  latched mode.
- cmd_addr  out  2  latched address.
- cmd_wdata  out  4  latched write data.
- wr_en  out  1  one-cycle write strobe (latched mode 2'b10).
- rd_en  out  1  one-cycle read strobe (latched mode 2'b01).
- bad_cmd  out  1  one-cycle strobe for latched mode 2'b11.
- busy  out  1  high whenever the FSM is not in IDLE.
- cmd_count  out  8  count of issued wr_en plus rd_en strobes.

## Operation
- Synchroniser: two flops each on switch[7:0] and push_btn; the second stage (switch_s, btn_s) is the only value used downstream.
- Debounce: register btn_stable (reset 0) and counter db_cnt (reset 0).
  - While btn_s == btn_stable: db_cnt clears to 0.
  - While btn_s != btn_stable: if db_cnt == DEBOUNCE_CYCLES-1, then btn_stable <= btn_s and db_cnt <= 0; otherwise db_cnt increments.
- FSM states: IDLE, LATCH, ISSUE, WAIT_REL.
  - IDLE: when btn_stable == 1, go to LATCH and capture switch_s into cmd_mode/cmd_addr/cmd_wdata on that edge.
  - LATCH: unconditionally go to ISSUE. On that edge, register wr_en=1 if cmd_mode==10, rd_en=1 if cmd_mode==01, bad_cmd=1 if cmd_mode==11. Mode 00 is a NOP and raises no strobe.
  - ISSUE: unconditionally go to WAIT_REL. All strobes return to 0. cmd_count increments by 1 if wr_en or rd_en was high; it wraps from 255 to 0.
  - WAIT_REL: return to IDLE when btn_stable == 0.
- cmd_* registers hold their value until the next capture. Switch changes after capture have no effect on the current command.
- Strobes are mutually exclusive and never high for more than one cycle per debounced press.
- Reset (any time, including mid-command): all outputs are 0, FSM is in IDLE, btn_stable=0, db_cnt=0, and the synchroniser flops are 0.
- A button held through reset release is treated as a new press: it issues one command after the debounce time.

## Timing
- Edge 1 is the first clock edge at which push_btn is sampled high; the button is held steady from then on. Then:
  - btn_s goes high after edge 2.
  - btn_stable goes high at edge D+2, where D = DEBOUNCE_CYCLES.
  - LATCH is entered (fields captured) at edge D+3.
  - The strobe is high for the single cycle following edge D+4.
  - busy rises at edge D+3 and falls one edge after btn_stable falls.
- Release is also debounced: btn_stable falls D+2 edges after the first sample of push_btn low.
- Any btn_s excursion shorter than D cycles is discarded, because db_cnt clears when btn_s returns to btn_stable.
- Bounce during WAIT_REL cannot produce a second command.
- Switch-to-capture latency is 2 cycles of synchroniser delay. Switches must be stable for 2 cycles before capture to be latched.

## Test plan
- DEBOUNCE_CYCLES=4; switch=8'b10_1011_10; clean press held 20 cycles -> cmd_addr=2, cmd_wdata=4'hB, cmd_mode=2 captured at edge 7; wr_en high for exactly one cycle after edge 8; rd_en=0; cmd_count=1.
- Mode 01 press with addr=3 -> single rd_en pulse and cmd_count increments. Mode 00 press -> no strobes and cmd_count unchanged. Mode 11 press -> single bad_cmd pulse and cmd_count unchanged.
- Bounce: push_btn toggles high 2 cycles, low 1, high 3, low 2, then steady high -> exactly one wr_en. Release bounce of the same pattern -> no extra strobe; busy drops only after a stable low.
- Glitch: push_btn high for 3 cycles (< D) -> btn_stable stays 0, busy stays 0, and no strobe.
- Switch change: switch data changed from 4'hB to 4'h5 during LATCH/ISSUE -> cmd_wdata stays 4'hB. The next press captures 4'h5.
- Reset and wrap:
  - rst_n asserted while in ISSUE -> all outputs 0 immediately (asynchronously).
  - Button held through reset release -> one command issued after debounce.
  - 256 write presses -> cmd_count wraps to 0.
